// File: rtl/dm_responder.sv
// Data-memory target for the single-cycle core: combinational loads, stores commit on the next edge.
// Zero-latency reads, one-edge store visibility; no backpressure, every legal access completes in its cycle.
module dm_responder #(
    parameter int DEPTH = 3072,
    parameter int AW    = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic [1:0]  width,
    input  logic        sign_ext,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        addr_err,
    output logic [31:0] st_count
);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   st_count_q;
    logic [31:0]   st_count_d;
    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic          access;
    logic          ld_ok;
    logic          st_ok;
    logic [31:0]   cur_word;
    logic [31:0]   word_d;
    logic [15:0]   half_sel;
    logic [7:0]    byte_sel;

    assign idx      = addr[AW+1:2];
    assign off      = addr[1:0];
    assign access   = we | re;
    assign cur_word = mem_q[idx];

    always_comb begin
        misalign = 1'b0;
        if (access) begin
            case (width)
                2'b01:   misalign = off[0];
                2'b10:   misalign = 1'b0;
                default: misalign = (off != 2'b00);
            endcase
        end
    end

    assign addr_err = access && (addr >= ADDR_LIMIT);
    assign ld_ok    = re && !misalign && !addr_err;
    assign st_ok    = we && !misalign && !addr_err;

    // Little-endian lane selection: offset 0 is bits [7:0].
    always_comb begin
        rdata    = '0;
        half_sel = off[1] ? cur_word[31:16] : cur_word[15:0];
        byte_sel = cur_word[{off, 3'b000} +: 8];
        if (ld_ok) begin
            case (width)
                2'b01:   rdata = {{16{sign_ext & half_sel[15]}}, half_sel};
                2'b10:   rdata = {{24{sign_ext & byte_sel[7]}}, byte_sel};
                default: rdata = cur_word;
            endcase
        end
    end

    always_comb begin
        word_d = cur_word;
        case (width)
            2'b01: begin
                if (off[1]) word_d[31:16] = wdata[15:0];
                else        word_d[15:0]  = wdata[15:0];
            end
            2'b10:   word_d[{off, 3'b000} +: 8] = wdata[7:0];
            default: word_d = wdata;
        endcase
    end

    assign st_count_d = st_ok ? st_count_q + 32'd1 : st_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            st_count_q <= '0;
        end else begin
            st_count_q <= st_count_d;
            if (st_ok) mem_q[idx] <= word_d;
        end
    end

    assign st_count = st_count_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && st_ok)
            $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, word_d);
    end
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Randomized and directed bench for dm_responder against a byte-addressed reference memory.
module tb_dm_responder;
    localparam int DEPTH = 3072;
    localparam int NBYTES = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, addr, wdata;
    logic        we, re, sign_ext;
    logic [1:0]  width;
    logic [31:0] rdata, st_count;
    logic        misalign, addr_err;

    int n_checks = 0;
    int n_fail   = 0;
    string phase = "init";

    logic [7:0]  ref_mem [NBYTES];
    logic [31:0] ref_cnt;
    logic [31:0] g;

    dm_responder #(.DEPTH(DEPTH), .AW(12)) dut (
        .clk(clk), .reset(reset), .pc(pc), .addr(addr), .wdata(wdata),
        .we(we), .re(re), .width(width), .sign_ext(sign_ext),
        .rdata(rdata), .misalign(misalign), .addr_err(addr_err), .st_count(st_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s/%s got=%h exp=%h", phase, tag, got, exp);
        end
    endtask

    function automatic int acc_size(input logic [1:0] w);
        return (w == 2'b01) ? 2 : (w == 2'b10) ? 1 : 4;
    endfunction

    function automatic logic ref_mis(input logic [1:0] w, input logic [31:0] a);
        return (a % acc_size(w)) != 0;
    endfunction

    function automatic logic ref_err(input logic [31:0] a);
        return longint'(a) >= longint'(NBYTES);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] w, input logic sx, input logic [31:0] a);
        int sz = acc_size(w);
        logic [31:0] v = '0;
        for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
        if (sx && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
        return v;
    endfunction

    task automatic do_reset(input logic st_we, input logic [31:0] st_a, input logic [31:0] st_d);
        reset = 1'b1; we = st_we; re = 1'b0; width = 2'b00; addr = st_a; wdata = st_d;
        @(posedge clk);
        #1;
        reset = 1'b0; we = 1'b0;
        for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
        ref_cnt = '0;
    endtask

    task automatic acc(input logic w, input logic r, input logic [1:0] wd, input logic sx,
                       input logic [31:0] a, input logic [31:0] d, output logic [31:0] got);
        logic act, m, e;
        logic [31:0] exp_rd;
        we = w; re = r; width = wd; sign_ext = sx; addr = a; wdata = d;
        pc = 32'h0040_0000 + 32'($urandom_range(0, 255)) * 4;
        @(negedge clk);
        act = w | r;
        m = act && ref_mis(wd, a);
        e = act && ref_err(a);
        exp_rd = (r && !m && !e) ? ref_load(wd, sx, a) : 32'h0;
        got = rdata;
        check_eq("rdata", rdata, exp_rd);
        check_eq("misalign", 32'(misalign), 32'(m));
        check_eq("addr_err", 32'(addr_err), 32'(e));
        check_eq("st_count", st_count, ref_cnt);
        @(posedge clk);
        if (w && !m && !e) begin
            for (int i = 0; i < acc_size(wd); i++) ref_mem[int'(a) + i] = d[8*i +: 8];
            ref_cnt = ref_cnt + 32'd1;
        end
        #1;
        we = 1'b0; re = 1'b0;
    endtask

    initial begin
        reset = 1'b1; pc = '0; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
        width = 2'b00; sign_ext = 1'b0; ref_cnt = '0;

        phase = "reset";
        do_reset(1'b0, 32'h0, 32'h0);
        acc(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, g);
        acc(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h0, g);
        check_eq("lw_after_reset", g, 32'h0);

        phase = "word";
        acc(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, g);
        acc(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h0, g);
        check_eq("lw_10", g, 32'hDEADBEEF);
        check_eq("cnt_1", st_count, 32'd1);

        phase = "merge";
        acc(1'b1, 1'b0, 2'b00, 1'b0, 32'h20, 32'h11223344, g);
        acc(1'b1, 1'b0, 2'b10, 1'b0, 32'h21, 32'h000000AB, g);
        acc(1'b0, 1'b1, 2'b00, 1'b0, 32'h20, 32'h0, g);
        check_eq("sb_word", g, 32'h1122AB44);
        acc(1'b0, 1'b1, 2'b10, 1'b1, 32'h21, 32'h0, g);
        check_eq("lb", g, 32'hFFFFFFAB);
        acc(1'b0, 1'b1, 2'b10, 1'b0, 32'h21, 32'h0, g);
        check_eq("lbu", g, 32'h000000AB);
        acc(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h00008001, g);
        acc(1'b0, 1'b1, 2'b00, 1'b0, 32'h20, 32'h0, g);
        check_eq("sh_word", g, 32'h8001AB44);
        acc(1'b0, 1'b1, 2'b01, 1'b1, 32'h22, 32'h0, g);
        check_eq("lh", g, 32'hFFFF8001);
        acc(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0, g);
        check_eq("lhu", g, 32'h00008001);

        phase = "misalign";
        acc(1'b1, 1'b0, 2'b00, 1'b0, 32'h16, 32'h12345678, g);
        check_eq("cnt_after_mis", st_count, 32'd4);
        acc(1'b0, 1'b1, 2'b00, 1'b0, 32'h14, 32'h0, g);
        check_eq("lw_14_unchanged", g, 32'h0);
        acc(1'b0, 1'b1, 2'b01, 1'b1, 32'h23, 32'h0, g);
        check_eq("lh_23", g, 32'h0);

        phase = "range";
        acc(1'b1, 1'b0, 2'b00, 1'b0, 32'h2FFC, 32'hCAFEF00D, g);
        acc(1'b0, 1'b1, 2'b00, 1'b0, 32'h2FFC, 32'h0, g);
        check_eq("lw_last", g, 32'hCAFEF00D);
        acc(1'b1, 1'b0, 2'b00, 1'b0, 32'h3000, 32'h55555555, g);
        acc(1'b0, 1'b1, 2'b00, 1'b0, 32'h3000, 32'h0, g);
        check_eq("lw_oob", g, 32'h0);

        phase = "rdw";
        acc(1'b1, 1'b1, 2'b00, 1'b0, 32'h40, 32'h5, g);
        check_eq("rdw_old", g, 32'h0);
        acc(1'b0, 1'b1, 2'b00, 1'b0, 32'h40, 32'h0, g);
        check_eq("rdw_new", g, 32'h5);

        phase = "midreset";
        acc(1'b1, 1'b0, 2'b00, 1'b0, 32'h8, 32'h77, g);
        do_reset(1'b1, 32'hC, 32'h99);
        acc(1'b0, 1'b1, 2'b00, 1'b0, 32'h8, 32'h0, g);
        check_eq("lw_8_cleared", g, 32'h0);
        acc(1'b0, 1'b1, 2'b00, 1'b0, 32'hC, 32'h0, g);
        check_eq("lw_c_cleared", g, 32'h0);
        check_eq("cnt_cleared", st_count, 32'h0);

        phase = "random";
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ra;
            int sel;
            sel = $urandom_range(0, 19);
            if (sel == 0)      ra = 32'(NBYTES - 8 + $urandom_range(0, 15));
            else if (sel == 1) ra = $urandom;
            else               ra = 32'($urandom_range(0, 127));
            acc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), ra, $urandom, g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder for the single-cycle MIPS core: the target end of the core's load/store interface.
- Services lw/lh/lhu/lb/lbu/sw/sh/sb issued by the datapath each cycle.
- Read is combinational, so a load completes in the same cycle. Stores commit at the next rising clock edge.
- Flags misaligned and out-of-range accesses, emits a store trace line, and counts committed stores.

Parameters:
- DEPTH, 3072, number of 32-bit words (byte address range 0x0000_0000 to 4*DEPTH-1).
- AW, 12, word-index width; must satisfy 2^AW >= DEPTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pc  in  32  PC of the instruction issuing the access (trace only).
- addr  in  32  byte address from the ALU.
- wdata  in  32  store data (rt value); low bytes used for sh/sb.
- we  in  1  store request this cycle.
- re  in  1  load request this cycle.
- width  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word).
- sign_ext  in  1  loads: 1 sign-extends half/byte, 0 zero-extends.
- rdata  out  32  load result, already extended.
- misalign  out  1  access not aligned to its width.
- addr_err  out  1  addr >= 4*DEPTH.
- st_count  out  32  number of stores committed since reset.

Behaviour:
- State: mem[0:DEPTH-1] of 32 bits; st_count register.
- Word index is addr[AW+1:2]; byte offset is addr[1:0].
- Reset (sampled at posedge with reset=1):
  - Every mem word and st_count go to 0.
  - Any concurrent we is ignored; reset has priority.
  - reset asserted mid-program clears all prior stores.
- Checks (combinational; valid only when we or re is 1, otherwise forced 0):
  - misalign = (width==01 && addr[0]) || (width==00/11 && addr[1:0]!=0).
  - addr_err = (addr >= 4*DEPTH).
- Load path (combinational):
  - If re && !misalign && !addr_err, select from W = mem[idx]:
    - word: rdata = W.
    - half: H = addr[1] ? W[31:16] : W[15:0]; rdata = {16 copies of (sign_ext ? H[15] : 0), H}.
    - byte: B = W[8*addr[1:0]+7 -: 8]; rdata = {24 copies of (sign_ext ? B[7] : 0), B}.
  - Otherwise rdata = 0.
  - Byte ordering is little-endian: offset 0 is W[7:0].
- Store path (posedge, reset=0):
  - If we && !misalign && !addr_err, merge into mem[idx]:
    - word: replace all 32 bits.
    - half: replace the half selected by addr[1] with wdata[15:0].
    - byte: replace the byte selected by addr[1:0] with wdata[7:0].
  - On each committed store: st_count <= st_count + 1, wrapping 0xFFFF_FFFF -> 0.
  - On each committed store, simulation-only $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2],2'b00}, merged_word).
  - A store that is misaligned or out of range changes nothing and prints nothing; the flag stays asserted for that cycle only.
- Read during write to the same word, same cycle: rdata shows the old contents; the new contents are visible from the next cycle.
- we and re both high: store rules and load rules each apply independently.
- No handshake or stall: every legal access completes in one cycle (load latency 0, store visible after 1 edge).

Test Plan:
- Reset then word round trip: assert reset 1 cycle, then sw 0xDEADBEEF @0x10 -> next cycle lw @0x10 gives rdata=0xDEADBEEF, st_count=1, trace shows *00000010 <= deadbeef.
- Byte/half merge and extension: with 0x11223344 @0x20, sb 0xAB @0x21 -> word 0x1122AB44; lb @0x21 -> 0xFFFFFFAB; lbu @0x21 -> 0x000000AB; sh 0x8001 @0x22 -> word 0x8001AB44; lh @0x22 -> 0xFFFF8001; lhu @0x22 -> 0x00008001.
- Misalignment: sw @0x14 with width=00 and addr 0x16 -> misalign=1, memory unchanged, st_count unchanged, no trace; lh @0x23 -> misalign=1, rdata=0.
- Range boundary: lw @0x2FFC (last word) works normally; sw @0x3000 -> addr_err=1, no write, rdata=0 for lw @0x3000.
- Read-during-write: sw 0x5 @0x40 with lw @0x40 in the same cycle -> rdata=old value (0); next cycle rdata=0x5.
- Reset mid-operation: store 0x77 @0x8, assert reset together with sw 0x99 @0xC -> afterwards both words read 0 and st_count=0.
